// File: rtl/wb_writer.sv
// Write-back stage: registers ALU results, or waits for and aligns load data before the register-file write.
// Optional load timeout (wait counter + ld_err pulse) is enabled by defining WB_LOAD_TIMEOUT_EN.
module wb_writer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [4:0]  in_rd,
  input  logic        in_we,
  input  logic [31:0] in_alu,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [4:0]  rd,
  output logic [31:0] wb_data,
  output logic        we,
  output logic        ld_err
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        we_q, we_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_funct3_q, ld_funct3_d;
  logic [1:0]  ld_addr_q, ld_addr_d;
  logic        ld_we_q, ld_we_d;
  logic [31:0] ld_data;
  logic        timeout_hit;

  function automatic logic [31:0] align_load(input logic [2:0]  f3,
                                             input logic [1:0]  a,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  align_load = {{24{b[7]}}, b};
      3'b001:  align_load = {{16{h[15]}}, h};
      3'b010:  align_load = w;
      3'b100:  align_load = {24'd0, b};
      3'b101:  align_load = {16'd0, h};
      default: align_load = w;
    endcase
  endfunction

  assign ld_data = align_load(ld_funct3_q, ld_addr_q, dmem_rdata);

  // Stall is combinational so read data arriving this cycle releases the pipeline at once.
  assign stall   = (state_q == WAIT) && !dmem_rvalid;
  assign rd      = rd_q;
  assign wb_data = wb_data_q;
  assign we      = we_q;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_err_q;

  assign timeout_hit = (state_q == WAIT) && !dmem_rvalid &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));
  assign ld_err      = ld_err_q;

  always_comb begin
    cnt_d = '0;
    if ((state_q == WAIT) && !dmem_rvalid && !timeout_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      ld_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ld_err_q <= timeout_hit;
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign ld_err         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wb_data_d   = wb_data_q;
    we_d        = 1'b0;
    ld_rd_d     = ld_rd_q;
    ld_funct3_d = ld_funct3_q;
    ld_addr_d   = ld_addr_q;
    ld_we_d     = ld_we_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_is_load) begin
            ld_rd_d     = in_rd;
            ld_funct3_d = in_funct3;
            ld_addr_d   = in_addr_lo;
            ld_we_d     = in_we;
            state_d     = WAIT;
          end else begin
            rd_d      = in_rd;
            wb_data_d = in_alu;
            we_d      = in_we && (in_rd != 5'd0);
          end
        end
      end
      WAIT: begin
        // Read data wins over a timeout landing in the same cycle.
        if (dmem_rvalid) begin
          rd_d      = ld_rd_q;
          wb_data_d = ld_data;
          we_d      = ld_we_q && (ld_rd_q != 5'd0);
          state_d   = IDLE;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_q        <= 5'd0;
      wb_data_q   <= 32'd0;
      we_q        <= 1'b0;
      ld_rd_q     <= 5'd0;
      ld_funct3_q <= 3'd0;
      ld_addr_q   <= 2'd0;
      ld_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wb_data_q   <= wb_data_d;
      we_q        <= we_d;
      ld_rd_q     <= ld_rd_d;
      ld_funct3_q <= ld_funct3_d;
      ld_addr_q   <= ld_addr_d;
      ld_we_q     <= ld_we_d;
    end
  end

endmodule
